// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the round-robin memory port arbiter.
// Holds the FSM state encoding, default geometry and the core index type.
package mem_arb_pkg;

  localparam int DEF_N_CORES = 4;
  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_DATA_W  = 16;

  // Width needed to index n cores; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CORE_IDX_W = idx_width(DEF_N_CORES);

  typedef logic [CORE_IDX_W-1:0] core_idx_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_rr_select.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo N_CORES; returns a one-hot grant and its index.
module rr_select
  import mem_arb_pkg::*;
#(
  parameter int N_CORES = DEF_N_CORES,
  localparam int IDX_W  = idx_width(N_CORES)
) (
  input  logic [N_CORES-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [N_CORES-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  logic [2*N_CORES-1:0] req2;
  logic [N_CORES-1:0]   rot;
  logic [IDX_W-1:0]     off;
  logic [IDX_W:0]       sum;

  // Rotating the doubled vector puts the pointer position at bit 0.
  assign req2  = {req, req};
  assign rot   = req2[ptr +: N_CORES];
  assign valid = |req;

  always_comb begin
    off = '0;
    for (int i = N_CORES - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = IDX_W'(i);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (IDX_W+1)'(N_CORES)) begin
      sum = sum - (IDX_W+1)'(N_CORES);
    end
    idx   = sum[IDX_W-1:0];
    grant = valid ? (N_CORES'(1) << idx) : '0;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous-read memory port among cores.
// Define READ_MERGE_EN to let same-address readers ride along with a read winner.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_CORES = DEF_N_CORES,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_CORES-1:0]        req,
  input  logic [N_CORES-1:0]        we,
  input  logic [N_CORES*ADDR_W-1:0] addr,
  input  logic [N_CORES*DATA_W-1:0] wdata,
  output logic [N_CORES-1:0]        ack,
  output logic [N_CORES*DATA_W-1:0] rdata,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      busy
);

  localparam int IDX_W = idx_width(N_CORES);

  arb_state_t         state_reg, state_next;
  logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [N_CORES-1:0] grant_reg, ack_reg;
  logic [N_CORES-1:0] eligible, win_grant, take_mask;
  logic [IDX_W-1:0]   win_idx;
  logic               win_valid;
  logic               load;
  logic               mem_we_reg;
  logic [ADDR_W-1:0]  mem_addr_reg;
  logic [DATA_W-1:0]  mem_wdata_reg;
  logic [ADDR_W-1:0]  addr_arr  [N_CORES];
  logic [DATA_W-1:0]  wdata_arr [N_CORES];
  logic [DATA_W-1:0]  rdata_reg [N_CORES];

  // A core in its ack cycle still shows its old req; keep it out of this round.
  assign eligible = req & ~ack_reg;

  rr_select #(.N_CORES(N_CORES)) u_rr_select (
    .req   (eligible),
    .ptr   (rr_ptr_reg),
    .grant (win_grant),
    .idx   (win_idx),
    .valid (win_valid)
  );

  genvar gi;
  generate
    for (gi = 0; gi < N_CORES; gi++) begin : g_core
      assign addr_arr[gi]  = addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = wdata[gi*DATA_W +: DATA_W];
      assign rdata[gi*DATA_W +: DATA_W] = rdata_reg[gi];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rdata_reg[gi] <= '0;
        end else if (state_reg == CAPTURE && grant_reg[gi] && !mem_we_reg) begin
          rdata_reg[gi] <= mem_rdata;
        end
      end
    end
  endgenerate

`ifdef READ_MERGE_EN
  logic [N_CORES-1:0] join_vec;
  generate
    for (gi = 0; gi < N_CORES; gi++) begin : g_join
      assign join_vec[gi] = eligible[gi] & ~we[gi] & (addr_arr[gi] == addr_arr[win_idx]);
    end
  endgenerate
  assign take_mask = we[win_idx] ? win_grant : (win_grant | join_vec);
`else
  assign take_mask = win_grant;
`endif

  assign rr_ptr_next = (win_idx == IDX_W'(N_CORES - 1)) ? '0 : win_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    mem_en     = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (win_valid) begin
          load       = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        mem_en     = 1'b1;
        state_next = CAPTURE;
      end
      CAPTURE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg    <= '0;
      grant_reg     <= '0;
      ack_reg       <= '0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      ack_reg <= (state_reg == CAPTURE) ? grant_reg : '0;
      if (load) begin
        rr_ptr_reg    <= rr_ptr_next;
        grant_reg     <= take_mask;
        mem_we_reg    <= we[win_idx];
        mem_addr_reg  <= addr_arr[win_idx];
        mem_wdata_reg <= wdata_arr[win_idx];
      end
    end
  end

  assign ack       = ack_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural synchronous-read memory.
// Build with READ_MERGE_EN defined to check the merged-read expectations instead.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        clk, rst_n;
  logic [3:0]  req, we, ack;
  logic [63:0] addr, wdata, rdata;
  logic        mem_en, mem_we, busy;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  logic [15:0] mem [0:65535];
  logic        tb_wr;
  logic [15:0] tb_wa, tb_wd;

  int errors, checks;

  mem_port_arbiter #(.N_CORES(4), .ADDR_W(16), .DATA_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .ack       (ack),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tb_wr) begin
      mem[tb_wa] <= tb_wd;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    tb_wr = 1'b1; tb_wa = a; tb_wd = d;
    tick();
    tb_wr = 1'b0;
  endtask

  task automatic set_core(input int k, input logic w, input logic [15:0] a, input logic [15:0] d);
    we[k] = w;
    addr[k*16 +: 16]  = a;
    wdata[k*16 +: 16] = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] ack_seen;
    checks++;
    if ({ack, busy, mem_en, mem_we} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl: ack/busy/en/we=%b required 0", {ack, busy, mem_en, mem_we});
    end
    checks++;
    if (rdata !== 64'h0) begin
      errors++; $display("FAIL reset_rdata: got %h required 0", rdata);
    end
    checks++;
    if ({mem_addr, mem_wdata} !== 32'h0) begin
      errors++; $display("FAIL reset_mem_bus: got %h required 0", {mem_addr, mem_wdata});
    end
    tick();
    rst_n = 1'b1;
    set_core(0, 1'b1, 16'd5, 16'hAAAA);
    req = 4'b0001;
    tick();
    checks++;
    if (mem_en !== 1'b1) begin
      errors++; $display("FAIL reset_pre_access: mem_en=%b required 1", mem_en);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_en, mem_we, busy, mem_addr, mem_wdata} !== 35'h0) begin
      errors++; $display("FAIL reset_mid_access: en/we/busy/addr/wdata=%h required 0",
                         {mem_en, mem_we, busy, mem_addr, mem_wdata});
    end
    req = '0;
    set_core(0, 1'b0, 16'd0, 16'd0);
    ack_seen = '0;
    for (int c = 0; c < 4; c++) begin
      tick();
      ack_seen = ack_seen | ack;
    end
    checks++;
    if (ack_seen !== 4'b0) begin
      errors++; $display("FAIL reset_no_ack: ack seen %b required 0000", ack_seen);
    end
    checks++;
    if (mem[5] !== 16'h5555) begin
      errors++; $display("FAIL reset_no_write: mem[5]=%h required 5555", mem[5]);
    end
    $display("reset mid-access: ack_seen=%b mem[5]=%h", ack_seen, mem[5]);
    rst_n = 1'b1;
  endtask

  task automatic test_all_reads();
    int cyc, got, busy_cnt;
    logic [63:0] exp_all;
    exp_all = {16'd6, 16'd5, 16'd2, 16'd1};
    do_reset();
    for (int k = 0; k < 4; k++) set_core(k, 1'b0, 16'(k), 16'h0);
    req = 4'b1111;
    cyc = 0; got = 0; busy_cnt = 0;
    while (got < 4 && cyc < 40) begin
      tick();
      cyc++;
      if (busy === 1'b1) busy_cnt++;
      if (ack !== 4'b0) begin
        $display("all_reads: ack=%b cycle=%0d rdata=%h", ack, cyc, rdata);
        checks++;
        if (ack !== (4'b0001 << got) || cyc != 3 * (got + 1)) begin
          errors++; $display("FAIL all_reads_order#%0d: ack=%b at cycle %0d required %b at cycle %0d",
                             got, ack, cyc, 4'b0001 << got, 3 * (got + 1));
        end
        checks++;
        if (rdata[got*16 +: 16] !== exp_all[got*16 +: 16]) begin
          errors++; $display("FAIL all_reads_data#%0d: rdata=%h required %h",
                             got, rdata[got*16 +: 16], exp_all[got*16 +: 16]);
        end
        req = req & ~ack;
        got++;
      end
    end
    req = '0;
    checks++;
    if (got != 4) begin
      errors++; $display("FAIL all_reads_timeout: acks=%0d required 4", got);
    end
    checks++;
    if (busy_cnt != 8) begin
      errors++; $display("FAIL all_reads_busy: busy cycles=%0d required 8", busy_cnt);
    end
    checks++;
    if (rdata !== exp_all) begin
      errors++; $display("FAIL all_reads_final: rdata=%h required %h", rdata, exp_all);
    end
  endtask

  task automatic test_single_write();
    set_core(2, 1'b1, 16'd3, 16'hE007);
    req = 4'b0100;
    tick();
    checks++;
    if ({mem_en, mem_we, busy, mem_addr, mem_wdata} !== {3'b111, 16'd3, 16'hE007}) begin
      errors++; $display("FAIL write_access: en/we/busy=%b addr=%h wdata=%h required 111 0003 e007",
                         {mem_en, mem_we, busy}, mem_addr, mem_wdata);
    end
    tick();
    checks++;
    if ({mem_en, busy, ack} !== 6'b01_0000) begin
      errors++; $display("FAIL write_capture: en/busy/ack=%b required 010000", {mem_en, busy, ack});
    end
    tick();
    checks++;
    if ({ack, busy, mem_en} !== 6'b0100_00) begin
      errors++; $display("FAIL write_ack: ack/busy/en=%b required 010000", {ack, busy, mem_en});
    end
    $display("single_write: ack=%b mem[3]=%h", ack, mem[3]);
    req = '0;
    set_core(2, 1'b0, 16'd0, 16'd0);
    tick();
    checks++;
    if ({ack, mem_en, mem_we, mem_addr} !== {4'b0, 1'b0, 1'b1, 16'd3}) begin
      errors++; $display("FAIL write_hold: ack=%b en=%b we=%b addr=%h required 0000 0 1 0003",
                         ack, mem_en, mem_we, mem_addr);
    end
    checks++;
    if (mem[3] !== 16'hE007) begin
      errors++; $display("FAIL write_mem: mem[3]=%h required e007", mem[3]);
    end
    checks++;
    if (rdata[2*16 +: 16] !== 16'd5) begin
      errors++; $display("FAIL write_rdata_kept: rdata[2]=%h required 0005", rdata[2*16 +: 16]);
    end
  endtask

  task automatic test_fairness();
    int cyc, got;
    logic [3:0] extra;
    do_reset();
    set_core(1, 1'b0, 16'd1, 16'd0);
    set_core(3, 1'b0, 16'd2, 16'd0);
    req = 4'b1010;
    cyc = 0; got = 0;
    while (got < 3 && cyc < 40) begin
      tick();
      cyc++;
      if (ack !== 4'b0) begin
        $display("fairness: ack=%b cycle=%0d", ack, cyc);
        checks++;
        if (ack !== ((got == 1) ? 4'b1000 : 4'b0010) || cyc != 3 * (got + 1)) begin
          errors++; $display("FAIL fairness_order#%0d: ack=%b at cycle %0d required %b at cycle %0d",
                             got, ack, cyc, (got == 1) ? 4'b1000 : 4'b0010, 3 * (got + 1));
        end
        if (ack[3]) req[3] = 1'b0;
        if (got == 2) req[1] = 1'b0;
        got++;
      end
    end
    req = '0;
    checks++;
    if (got != 3) begin
      errors++; $display("FAIL fairness_timeout: acks=%0d required 3", got);
    end
    extra = '0;
    for (int c = 0; c < 6; c++) begin
      tick();
      extra = extra | ack;
    end
    checks++;
    if (extra !== 4'b0) begin
      errors++; $display("FAIL fairness_no_extra: ack seen %b required 0000", extra);
    end
    checks++;
    if ({rdata[3*16 +: 16], rdata[1*16 +: 16]} !== {16'd5, 16'd2}) begin
      errors++; $display("FAIL fairness_data: rdata3/rdata1=%h required 00050002",
                         {rdata[3*16 +: 16], rdata[1*16 +: 16]});
    end
  endtask

  task automatic test_read_merge();
    int pulses, n_ev;
    logic [3:0] ev_ack [2];
    int ev_cyc [2];
    do_reset();
    set_core(0, 1'b0, 16'd4, 16'd0);
    set_core(1, 1'b0, 16'd4, 16'd0);
    req = 4'b0011;
    pulses = 0; n_ev = 0;
    ev_ack[0] = '0; ev_ack[1] = '0; ev_cyc[0] = 0; ev_cyc[1] = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (mem_en === 1'b1) pulses++;
      if (ack !== 4'b0) begin
        $display("read_merge: ack=%b cycle=%0d", ack, c);
        if (n_ev < 2) begin
          ev_ack[n_ev] = ack;
          ev_cyc[n_ev] = c;
        end
        n_ev++;
        req = req & ~ack;
      end
    end
    req = '0;
`ifdef READ_MERGE_EN
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL merge_pulses: mem_en pulses=%0d required 1", pulses);
    end
    checks++;
    if (n_ev != 1 || ev_ack[0] !== 4'b0011 || ev_cyc[0] != 3) begin
      errors++; $display("FAIL merge_ack: events=%0d first=%b at %0d required 1 event 0011 at 3",
                         n_ev, ev_ack[0], ev_cyc[0]);
    end
`else
    checks++;
    if (pulses != 2) begin
      errors++; $display("FAIL merge_pulses: mem_en pulses=%0d required 2", pulses);
    end
    checks++;
    if (n_ev != 2 || ev_ack[0] !== 4'b0001 || ev_cyc[0] != 3 || ev_ack[1] !== 4'b0010 || ev_cyc[1] != 6) begin
      errors++; $display("FAIL merge_ack: events=%0d %b@%0d %b@%0d required 2 events 0001@3 0010@6",
                         n_ev, ev_ack[0], ev_cyc[0], ev_ack[1], ev_cyc[1]);
    end
`endif
    checks++;
    if ({rdata[1*16 +: 16], rdata[0 +: 16]} !== {16'd3, 16'd3}) begin
      errors++; $display("FAIL merge_data: rdata1/rdata0=%h required 00030003",
                         {rdata[1*16 +: 16], rdata[0 +: 16]});
    end
  endtask

  task automatic test_back_to_back();
    int cyc, n;
    set_core(0, 1'b0, 16'd7, 16'd0);
    req = 4'b0001;
    cyc = 0; n = 0;
    while (n < 3 && cyc < 40) begin
      tick();
      cyc++;
      if (ack !== 4'b0) begin
        $display("back_to_back: ack=%b cycle=%0d rdata0=%h", ack, cyc, rdata[0 +: 16]);
        checks++;
        if (ack !== 4'b0001 || cyc != ((n == 0) ? 3 : (n == 1) ? 7 : 11)) begin
          errors++; $display("FAIL b2b_ack#%0d: ack=%b at cycle %0d required 0001 at cycle %0d",
                             n, ack, cyc, (n == 0) ? 3 : (n == 1) ? 7 : 11);
        end
        checks++;
        if (rdata[0 +: 16] !== ((n == 2) ? 16'h7E7E : 16'h0777)) begin
          errors++; $display("FAIL b2b_data#%0d: rdata0=%h required %h",
                             n, rdata[0 +: 16], (n == 2) ? 16'h7E7E : 16'h0777);
        end
        if (n == 0) set_core(0, 1'b1, 16'd7, 16'h7E7E);
        else if (n == 1) set_core(0, 1'b0, 16'd7, 16'd0);
        else req = '0;
        n++;
      end
    end
    req = '0;
    checks++;
    if (n != 3) begin
      errors++; $display("FAIL b2b_timeout: acks=%0d required 3", n);
    end
    checks++;
    if (rdata[1*16 +: 16] !== 16'd3) begin
      errors++; $display("FAIL b2b_other_core: rdata1=%h required 0003", rdata[1*16 +: 16]);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    req = '0; we = '0; addr = '0; wdata = '0;
    tb_wr = 1'b0; tb_wa = '0; tb_wd = '0;
    preload(16'd0, 16'd1);
    preload(16'd1, 16'd2);
    preload(16'd2, 16'd5);
    preload(16'd3, 16'd6);
    preload(16'd4, 16'd3);
    preload(16'd5, 16'h5555);
    preload(16'd7, 16'h0777);
    test_reset();
    test_all_reads();
    test_single_write();
    test_fairness();
    test_read_merge();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, synchronous-read data memory between N_CORES core-side request ports.
- Arbitration is round-robin, with a req/ack handshake per core.
- Sits between the per-core load/store ports (address, write data, write enable) and the data memory inside the memory controller.
- Serialises accesses; returns read data to each requester in a registered per-core output.

Parameters:
- N_CORES, 4, number of requesting cores.
- ADDR_W, 16, word-address width.
- DATA_W, 16, data word width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N_CORES  per-core access request; held until matching ack.
- we  in  N_CORES  per-core write enable (1 = write, 0 = read); stable while req.
- addr  in  N_CORES*ADDR_W  packed per-core addresses; core k at slice [k*ADDR_W +: ADDR_W].
- wdata  in  N_CORES*DATA_W  packed per-core write data.
- ack  out  N_CORES  one-cycle completion pulse per core.
- rdata  out  N_CORES*DATA_W  packed per-core read data; registered.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid the cycle after mem_en with mem_we=0.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, rst_n=0) forces:
  - state=IDLE, rr_ptr=0, ack=0, rdata=0.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0.
- Reset mid-access:
  - Any in-flight access is dropped; no ack is issued.
  - If rst_n falls before the ACCESS-ending edge, no memory write occurs.
- FSM states: IDLE, ACCESS, CAPTURE.
- IDLE:
  - eligible = req & ~ack (a core being acked this cycle is masked).
  - If eligible is nonzero, winner = first set bit searching upward from rr_ptr, modulo N_CORES.
  - Register winner's we/addr/wdata into mem_we/mem_addr/mem_wdata and store the winner index; go to ACCESS.
  - rr_ptr <= (winner+1) mod N_CORES.
  - If eligible is zero, stay in IDLE.
- ACCESS:
  - mem_en=1 for exactly this cycle; memory samples at the ending edge; go to CAPTURE.
- CAPTURE:
  - mem_en=0.
  - For a read: rdata[winner] <= mem_rdata at the ending edge.
  - ack[winner] <= 1 for the next cycle only; go to IDLE.
- Latency:
  - req sampled at edge E0 gives ack high in the cycle after E2, with rdata valid in that same cycle.
  - Throughput is one access per 3 cycles under continuous demand.
- rdata[k] holds its value until core k's next completed read.
- Writes leave rdata unchanged.
- Other cores' rdata is never disturbed by an access.
- Cores drop or change req in the ack cycle; the arbiter ignores a req held past its ack cycle only for that one cycle (re-request is legal).
- Simultaneous requests from all cores: served in order rr_ptr, rr_ptr+1, ...; no core waits more than N_CORES-1 grants.
- mem_we/mem_addr/mem_wdata hold their last values outside ACCESS.

Optional Feature:
- Macro READ_MERGE_EN.
- When defined:
  - In IDLE, if the winner is a read, every other eligible core with we=0 and an identical addr joins the access.
  - Joined cores get rdata loaded and ack pulsed in the same cycle as the winner.
  - rr_ptr advances past the winner only.
- When undefined: strictly one core per access, as above.

Decomposition:
- Package mem_arb_pkg holds: state enum (IDLE/ACCESS/CAPTURE), N_CORES/ADDR_W/DATA_W defaults, core index type.
- One sub-module, rr_select: combinational round-robin priority picker (req vector + pointer -> one-hot grant + index).

Test Plan:
1. Reset mid-ACCESS, with core 0 writing 0xAAAA to addr 5 -> no ack; mem[5] unchanged; all outputs 0.
2. Core 2 alone writes 0xE007 to addr 3 -> mem_en=1 with mem_we=1, addr 3, data 0xE007 for one cycle; ack[2] 3 cycles after req; busy high for 2 cycles.
3. All 4 cores read addrs 0,1,2,3 from reset (mem holds 1,2,5,6) -> acks in order 0,1,2,3, 3 cycles apart; rdata = 1,2,5,6.
4. Core 1 requests continuously, re-asserting after each ack, while core 3 requests once -> grants alternate 1,3,1; core 3 is never starved.
5. READ_MERGE_EN defined; cores 0 and 1 read addr 4 (value 3) simultaneously -> single mem_en pulse; ack[0] and ack[1] in the same cycle; both rdata=3. With the macro undefined -> two accesses.
6. Core 0 reads addr 7 and core 0 writes addr 7 in back-to-back requests -> read returns the old value; the following read returns the newly written value.
